// File: rtl/ky32_pkg.sv
// Shared KY32 buffering definitions: occupancy state encoding reused by the
// skid register and later buffering blocks.
package ky32_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // The encoding is chosen so the state value is the occupancy itself.
    function automatic logic [1:0] state_count(input skid_state_t s);
        return s;
    endfunction

endpackage

// File: rtl/ky32_skid_reg_if.sv
// Valid/ready handshake bundle around a KY32 skid register stage.
// master = the stage itself, slave = the surrounding logic driving it.
interface ky32_skid_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       count;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/ky32_dffe_w.sv
// WIDTH-wide enable register with async active-low clear and a synchronous
// flush that reloads the reset value.
module ky32_dffe_w #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            q <= RST_VAL;
        else if (flush)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/ky32_skid_reg.sv
// Two-entry skid pipeline register: full throughput, all handshake outputs
// decoded from flops so out_ready never reaches in_ready combinationally.
module ky32_skid_reg
    import ky32_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    ky32_skid_reg_if.master  bus
);

    skid_state_t      state;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (bus.in_valid) state <= BUSY;
                BUSY: begin
                    if (bus.in_valid && !bus.out_ready)
                        state <= FULL;
                    else if (!bus.in_valid && bus.out_ready)
                        state <= EMPTY;
                end
                FULL: if (bus.out_ready) state <= BUSY;
                default: state <= EMPTY;
            endcase
        end
    end

    // When FULL the head refills from the skid entry; otherwise from upstream.
    always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = bus.in_data;
        case (state)
            EMPTY: main_en = bus.in_valid;
            BUSY: begin
                main_en = bus.in_valid && bus.out_ready;
                skid_en = bus.in_valid && !bus.out_ready;
            end
            FULL: begin
                main_en = bus.out_ready;
                main_d  = skid_q;
            end
            default: ;
        endcase
    end

    ky32_dffe_w #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_main (
        .clk   (clk),
        .clrn  (clrn),
        .flush (flush),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    ky32_dffe_w #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk   (clk),
        .clrn  (clrn),
        .flush (flush),
        .en    (skid_en),
        .d     (bus.in_data),
        .q     (skid_q)
    );

    assign bus.out_valid = (state != EMPTY);
    assign bus.in_ready  = (state != FULL);
    assign bus.out_data  = main_q;
    assign bus.count     = state_count(state);

endmodule

// File: tb/tb_ky32_skid_reg.sv
// Directed-vector and queue-model bench for ky32_skid_reg (WIDTH = 8).
module tb_ky32_skid_reg;

    logic clk;
    logic clrn;
    logic flush;

    int checks;
    int failures;

    ky32_skid_reg_if #(.WIDTH(8)) bus ();

    ky32_skid_reg #(
        .WIDTH   (8),
        .RST_VAL (8'h00)
    ) dut (
        .clk   (clk),
        .clrn  (clrn),
        .flush (flush),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       exp_ov;
        logic       exp_ir;
        logic [1:0] exp_cnt;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [19];

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic f, input logic iv, input logic [7:0] d,
                                 input logic ordy);
        @(negedge clk);
        flush         = f;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ov, input logic ir,
                               input logic [1:0] cnt, input logic [7:0] data,
                               input bit check_data);
        checks++;
        if (bus.out_valid !== ov) begin
            failures++;
            $display("[TB] FAIL %s out_valid: got %b expected %b", name, bus.out_valid, ov);
        end
        checks++;
        if (bus.in_ready !== ir) begin
            failures++;
            $display("[TB] FAIL %s in_ready: got %b expected %b", name, bus.in_ready, ir);
        end
        checks++;
        if (bus.count !== cnt) begin
            failures++;
            $display("[TB] FAIL %s count: got %0d expected %0d", name, bus.count, cnt);
        end
        if (check_data) begin
            checks++;
            if (bus.out_data !== data) begin
                failures++;
                $display("[TB] FAIL %s out_data: got %h expected %h", name, bus.out_data, data);
            end
        end
    endtask

    logic [7:0] model_q [$];

    initial begin
        checks        = 0;
        failures      = 0;
        clrn          = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        //              flush iv data   ordy  ov ir cnt   data
        vecs[0]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 2'd1, 8'h01};
        vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 2'd1, 8'h02};
        vecs[2]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 2'd1, 8'h03};
        vecs[3]  = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 2'd0, 8'h03};
        vecs[4]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 2'd1, 8'hA1};
        vecs[5]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA1};
        vecs[6]  = '{1'b0, 1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA1};
        vecs[7]  = '{1'b0, 1'b1, 8'hB3, 1'b1, 1'b1, 1'b1, 2'd1, 8'hA2};
        vecs[8]  = '{1'b0, 1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA2};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 8'hB3};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'hB3};
        vecs[11] = '{1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 1'b1, 2'd1, 8'hC1};
        vecs[12] = '{1'b0, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 2'd2, 8'hC1};
        vecs[13] = '{1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[16] = '{1'b0, 1'b1, 8'hD4, 1'b0, 1'b1, 1'b1, 2'd1, 8'hD4};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd1, 8'hD4};
        vecs[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00};

        #12;
        checkOutput("reset", 1'b0, 1'b1, 2'd0, 8'h00, 1'b1);
        @(negedge clk);
        clrn = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_ir,
                        vecs[i].exp_cnt, vecs[i].exp_data, 1'b1);
        end

        // Streaming: one word per cycle, head shows the word accepted last edge.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 1'b1);
            checkOutput($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 8'(i), 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("stream_drain", 1'b0, 1'b1, 2'd0, 8'h10, 1'b1);

        // Async reset mid-cycle while FULL.
        applyStimulus(1'b0, 1'b1, 8'hE1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hE2, 1'b0);
        checkOutput("prefill_full", 1'b1, 1'b0, 2'd2, 8'hE1, 1'b1);
        #2;
        clrn = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 1'b1, 2'd0, 8'h00, 1'b1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("after_reset", 1'b0, 1'b1, 2'd0, 8'h00, 1'b1);

        // Random traffic against a two-entry queue model.
        model_q.delete();
        for (int n = 0; n < 10000; n++) begin
            logic       iv;
            logic       ordy;
            logic [7:0] d;
            int         sz;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            d    = 8'($urandom_range(0, 255));
            sz   = model_q.size();
            applyStimulus(1'b0, iv, d, ordy);
            if (ordy && sz > 0)
                void'(model_q.pop_front());
            if (iv && sz < 2)
                model_q.push_back(d);
            checkOutput($sformatf("rand%0d", n), model_q.size() > 0, model_q.size() < 2,
                        2'(model_q.size()),
                        (model_q.size() > 0) ? model_q[0] : 8'h00,
                        model_q.size() > 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
